adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe_pkg.sv | 20 ++
 rtl/adder_pipe_segment.sv | 14 +
 rtl/adder_pipe.sv | 124 ++++++++++++
 tb/tb_adder_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared defaults and helpers for the segmented carry-pipeline adder.
// Also provides the DATA_WIDTH and ADDER_SEGMENTS default macros.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDER_SEGMENTS
`define ADDER_SEGMENTS 4
`endif

package adder_pipe_pkg;

    localparam int DefWidth    = `DATA_WIDTH;
    localparam int DefSegments = `ADDER_SEGMENTS;

    // Signed overflow: operands share a sign that the sum does not.
    function automatic logic signedOvf(input logic aMsb, input logic bMsb, input logic sMsb);
        return (aMsb == bMsb) && (sMsb != aMsb);
    endfunction

endpackage

// File: rtl/adder_pipe_segment.sv
// Combinational slice adder with carry-in and carry-out.
module adder_segment #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe.sv
// Carry-pipelined adder/subtractor with valid/ready flow control.
// Define ADDER_PIPE_SAT_EN for saturating signed results.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDER_SEGMENTS
`define ADDER_SEGMENTS 4
`endif

module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DefWidth,
    parameter int SEGMENTS   = DefSegments
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dst,
    output logic                  carry,
    output logic                  ovf
);

    localparam int SliceW = DATA_WIDTH / SEGMENTS;
    localparam int Last   = SEGMENTS - 1;

    logic                  advance;
    logic [DATA_WIDTH-1:0] bEff;

    logic [DATA_WIDTH-1:0] aReg    [SEGMENTS];
    logic [DATA_WIDTH-1:0] bReg    [SEGMENTS];
    logic [DATA_WIDTH-1:0] sumReg  [SEGMENTS];
    logic [DATA_WIDTH-1:0] nextSum [SEGMENTS];
    logic                  carryReg[SEGMENTS];
    logic                  validReg[SEGMENTS];
    logic                  segCout [SEGMENTS];

    assign bEff = sub ? ~srcB : srcB;

    for (genvar k = 0; k < SEGMENTS; k++) begin : gSeg
        logic [SliceW-1:0]     sliceA;
        logic [SliceW-1:0]     sliceB;
        logic [SliceW-1:0]     segSum;
        logic [DATA_WIDTH-1:0] prevSum;
        logic [DATA_WIDTH-1:0] merged;
        logic                  cin;

        if (k == 0) begin : gFirst
            // Subtraction's +1 enters as the carry-in of the lowest slice.
            assign sliceA  = srcA[0 +: SliceW];
            assign sliceB  = bEff[0 +: SliceW];
            assign cin     = sub;
            assign prevSum = '0;
        end else begin : gRest
            assign sliceA  = aReg[k-1][k*SliceW +: SliceW];
            assign sliceB  = bReg[k-1][k*SliceW +: SliceW];
            assign cin     = carryReg[k-1];
            assign prevSum = sumReg[k-1];
        end

        adder_segment #(.W(SliceW)) uSeg (
            .a   (sliceA),
            .b   (sliceB),
            .cin (cin),
            .sum (segSum),
            .cout(segCout[k])
        );

        always_comb begin
            merged = prevSum;
            merged[k*SliceW +: SliceW] = segSum;
        end

        assign nextSum[k] = merged;
    end

    // The whole pipeline moves as one; a stalled output freezes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SEGMENTS; k++) begin
                aReg[k]     <= '0;
                bReg[k]     <= '0;
                sumReg[k]   <= '0;
                carryReg[k] <= 1'b0;
                validReg[k] <= 1'b0;
            end
        end else if (advance) begin
            aReg[0]     <= srcA;
            bReg[0]     <= bEff;
            sumReg[0]   <= nextSum[0];
            carryReg[0] <= segCout[0];
            validReg[0] <= in_valid;
            for (int k = 1; k < SEGMENTS; k++) begin
                aReg[k]     <= aReg[k-1];
                bReg[k]     <= bReg[k-1];
                sumReg[k]   <= nextSum[k];
                carryReg[k] <= segCout[k];
                validReg[k] <= validReg[k-1];
            end
        end
    end

    assign out_valid = validReg[Last];
    assign in_ready  = !out_valid || out_ready;
    assign advance   = in_ready;
    assign carry     = carryReg[Last];
    assign ovf       = signedOvf(aReg[Last][DATA_WIDTH-1], bReg[Last][DATA_WIDTH-1],
                                 sumReg[Last][DATA_WIDTH-1]);

`ifdef ADDER_PIPE_SAT_EN
    // Positive overflow wraps to a negative sum, so the sum's MSB picks the clamp.
    assign dst = ovf ? {~sumReg[Last][DATA_WIDTH-1], {(DATA_WIDTH-1){sumReg[Last][DATA_WIDTH-1]}}}
                     : sumReg[Last];
`else
    assign dst = sumReg[Last];
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed table, stall/reset sequences, random scoreboard.
module tb_adder_pipe;

    localparam int W = 32;
    localparam int S = 4;
`ifdef ADDER_PIPE_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, in_ready, sub = 1'b0, out_valid, out_ready = 1'b1, carry, ovf;
    logic [W-1:0] srcA = '0, srcB = '0, dst;

    logic         sValid = 1'b0, sReady, sSub = 1'b0, sOutValid, sOutReady = 1'b1, sCarry, sOvf;
    logic [7:0]   sA = '0, sB = '0, sDst;

    adder_pipe #(.DATA_WIDTH(W), .SEGMENTS(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .srcA(srcA), .srcB(srcB), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .dst(dst), .carry(carry), .ovf(ovf)
    );

    adder_pipe #(.DATA_WIDTH(8), .SEGMENTS(1)) dutSmall (
        .clk(clk), .rst_n(rst_n), .in_valid(sValid), .in_ready(sReady),
        .srcA(sA), .srcB(sB), .sub(sSub), .out_valid(sOutValid), .out_ready(sOutReady),
        .dst(sDst), .carry(sCarry), .ovf(sOvf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] d;
        logic         c;
        logic         o;
    } vec_t;

    int vecs = 0;
    int errs = 0;
    int outCount = 0;
    bit monEn = 1'b1;
    bit heldValid = 1'b0;
    logic [W+1:0] held;
    logic [W+1:0] expQ[$];
    logic [W+1:0] expItem;

    // Reference: plain signed/unsigned arithmetic, then wrap or clamp.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa, sb, r, ua, ub;
        logic c, o;
        logic [W-1:0] d;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = s ? sa - sb : sa + sb;
        o  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        c  = s ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
        d  = r[W-1:0];
        if (SatEn && o) d = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return {c, o, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (monEn && rst_n) begin
            if (out_valid && out_ready) begin
                outCount++;
                if (expQ.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected result: got %h, expected none", {carry, ovf, dst});
                end else begin
                    expItem = expQ.pop_front();
                    check("scoreboard", {30'b0, carry, ovf, dst}, {30'b0, expItem});
                end
            end
            if (out_valid && !out_ready) begin
                if (heldValid) check("stall hold", {30'b0, carry, ovf, dst}, {30'b0, held});
                held = {carry, ovf, dst};
                heldValid = 1'b1;
            end else begin
                heldValid = 1'b0;
            end
            if (in_valid && in_ready) expQ.push_back(model(srcA, srcB, sub));
        end else begin
            heldValid = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bit acc = 1'b0;
        in_valid = 1'b1;
        srcA = a;
        srcB = b;
        sub = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            vecs++;
            errs++;
            $display("FAIL accept timeout: got in_ready=0, expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic waitOut(input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (!out_valid) begin
            vecs++;
            errs++;
            $display("FAIL %s timeout: got out_valid=0, expected 1", name);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check(name, 64'(expQ.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    vec_t tbl[6];
    bit   done;
    bit   sawLow;
    int   lat;
    int   countBefore;

    initial begin
        tbl[0] = '{32'h1, 32'h8, 1'b0, 32'h9, 1'b0, 1'b0};
        tbl[1] = '{32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h1, 1'b0, SatEn ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'h8000_0000, 32'h1, 1'b1, SatEn ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[4] = '{32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0};

        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset dst/carry/ovf", {30'b0, carry, ovf, dst}, 64'd0);
        check("reset small out_valid", 64'(sOutValid), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 64'(in_ready), 64'd1);
        step();

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].s);
            lat = 1;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            check($sformatf("latency[%0d]", i), 64'(lat), 64'(S));
            check($sformatf("table[%0d]", i), {30'b0, carry, ovf, dst}, {30'b0, tbl[i].c, tbl[i].o, tbl[i].d});
            step();
        end

        // Back-to-back results on consecutive cycles.
        send(32'd9, 32'd6, 1'b0);
        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        waitOut("b2b");
        check("b2b first", {31'b0, carry, dst}, {31'b0, 1'b0, 32'd15});
        step();
        check("b2b second", {30'b0, out_valid, carry, dst}, {30'b0, 1'b1, 1'b1, 32'd0});
        step();

        // Output stall while streaming 1..6.
        countBefore = outCount;
        sawLow = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(W'(i), 32'd1, 1'b0);
            end
            begin
                out_ready = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (!in_ready) sawLow = 1'b1;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        check("stall in_ready low", 64'(sawLow), 64'd1);
        drain("stall drain");
        check("stall count", 64'(outCount - countBefore), 64'd6);

        // Reset with operations in flight.
        out_ready = 1'b0;
        send(32'd10, 32'd20, 1'b0);
        send(32'd30, 32'd40, 1'b1);
        send(32'd50, 32'd60, 1'b0);
        step();
        check("pre-reset out_valid", 64'(out_valid), 64'd1);
        #2;
        monEn = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset outputs", {30'b0, carry, ovf, dst}, 64'd0);
        expQ.delete();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        monEn = 1'b1;
        @(negedge clk);
        check("in_ready after mid reset", 64'(in_ready), 64'd1);
        countBefore = outCount;
        repeat (10) step();
        check("no stale results", 64'(outCount - countBefore), 64'd0);

        // Randomized traffic against the scoreboard.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send(pick(), pick(), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        drain("random drain");

        // Single-segment 8-bit instance.
        sA = 8'd200;
        sB = 8'd100;
        sValid = 1'b1;
        @(negedge clk);
        check("small in_ready", 64'(sReady), 64'd1);
        step();
        sValid = 1'b0;
        check("small latency", 64'(sOutValid), 64'd1);
        check("small result", {54'b0, sCarry, sOvf, sDst}, {54'b0, 1'b1, 1'b0, 8'd44});
        step();
        check("small drained", 64'(sOutValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
